// File: rtl/long_fifo_pkg.sv
// Shared sizing helpers, default thresholds and parameter legality check for long_fifo_sc.
// No logic; elaboration-time only.
package long_fifo_pkg;

    localparam int DEF_DSIZE        = 18;
    localparam int DEF_DEPTH        = 8192;
    localparam int DEF_AEMPTY_LVL   = 16;
    localparam int DEF_AFULL_MARGIN = 16;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(input int dsize, input int depth,
                                     input int afull_lvl, input int aempty_lvl);
        return (dsize >= 1) && (depth >= 4) &&
               (aempty_lvl < afull_lvl) && (afull_lvl <= depth);
    endfunction

endpackage

// File: rtl/long_fifo_ram.sv
// Simple-dual-port RAM, DSIZE x DEPTH: one write port, one registered read port with enable.
// Latency: read data one edge after rd_vld. No backpressure; caller guarantees addresses are legal.
// Read register doubles as the FIFO head register, hence its reset.
module long_fifo_ram #(
    parameter int DSIZE = 18,
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DSIZE-1:0] wr_dat,
    input  logic             rd_vld,
    input  logic [AW-1:0]    rd_addr,
    output logic [DSIZE-1:0] rd_dat
);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_vld)
            mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            rd_dat <= '0;
        else if (rd_vld)
            rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/long_fifo_sc.sv
// Single-clock FWFT FIFO on one inferred SDP RAM with count and almost-full/empty thresholds.
// Latency: write visible on dout one edge after it is accepted; reads sustain one word per cycle.
// Backpressure: writes while full are dropped; reads while empty are ignored. Optional sticky
// overflow/underflow flags are built only when LONG_FIFO_ERR_FLAG_EN is defined.
module long_fifo_sc
    import long_fifo_pkg::*;
#(
    parameter int DSIZE      = DEF_DSIZE,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - DEF_AFULL_MARGIN,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic [DSIZE-1:0]           din,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [DSIZE-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t PTR_LAST  = ptr_t'(DEPTH - 1);
    localparam cnt_t CNT_FULL  = cnt_t'(DEPTH);
    localparam cnt_t CNT_AFULL = cnt_t'(AFULL_LVL);
    localparam cnt_t CNT_AEMPT = cnt_t'(AEMPTY_LVL);

    if (!params_ok(DSIZE, DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
        $error("long_fifo_sc: illegal DSIZE/DEPTH/AFULL_LVL/AEMPTY_LVL combination");
    end

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
    endfunction

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t count_q;
    logic dout_vld;

    logic wr_acc;
    logic rd_acc;
    logic ram_has_word;
    logic prefetch;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && dout_vld;

    // Words still sitting in RAM: everything counted minus the one held in the head register.
    assign ram_has_word = count_q > {{(CW-1){1'b0}}, dout_vld};
    assign prefetch     = ram_has_word && (!dout_vld || rd_acc);

    long_fifo_ram #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_vld  (wr_acc),
        .wr_addr (wr_ptr),
        .wr_dat  (din),
        .rd_vld  (prefetch),
        .rd_addr (rd_ptr),
        .rd_dat  (dout)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            dout_vld <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            if (prefetch)
                rd_ptr <= ptr_inc(rd_ptr);

            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase

            if (prefetch)
                dout_vld <= 1'b1;
            else if (rd_acc)
                dout_vld <= 1'b0;
        end
    end

    assign count        = count_q;
    assign empty        = !dout_vld;
    assign full         = (count_q == CNT_FULL);
    assign almost_full  = (count_q >= CNT_AFULL);
    assign almost_empty = (count_q <= CNT_AEMPT);

`ifdef LONG_FIFO_ERR_FLAG_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow_q <= 1'b1;
            if (rd_en && empty)
                underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_long_fifo_sc.sv
// Self-checking bench for long_fifo_sc: DEPTH=8 and DEPTH=6 instances against a queue model.
module tb_long_fifo_sc;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic        wr_en [2];
    logic        rd_en [2];
    logic [17:0] din   [2];
    logic [17:0] dout  [2];
    logic        full  [2];
    logic        empty [2];
    logic        afull [2];
    logic        aempty[2];
    logic        ovf   [2];
    logic        unf   [2];
    logic [3:0]  count0;
    logic [2:0]  count1;

    long_fifo_sc #(.DSIZE(18), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(2)) u_dut0 (
        .clock(clock), .rst_n(rst_n), .din(din[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
        .dout(dout[0]), .full(full[0]), .empty(empty[0]), .almost_full(afull[0]),
        .almost_empty(aempty[0]), .count(count0), .overflow(ovf[0]), .underflow(unf[0]));

    long_fifo_sc #(.DSIZE(18), .DEPTH(6), .AFULL_LVL(4), .AEMPTY_LVL(1)) u_dut1 (
        .clock(clock), .rst_n(rst_n), .din(din[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
        .dout(dout[1]), .full(full[1]), .empty(empty[1]), .almost_full(afull[1]),
        .almost_empty(aempty[1]), .count(count1), .overflow(ovf[1]), .underflow(unf[1]));

    // Reference model: a word is stored with the edge it was written on and becomes
    // presentable on dout from the following edge onward, once it reaches the head.
    typedef struct {
        logic [17:0] d;
        int          t;
    } ent_t;

    ent_t mq [2][$];
    bit   m_emp [2];
    bit   m_ovf [2];
    bit   m_unf [2];
    int   dep   [2] = '{8, 6};
    int   afl   [2] = '{6, 4};
    int   ael   [2] = '{2, 1};
    int   edge_no = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int cnt_of(input int k);
        return (k == 0) ? int'(count0) : int'(count1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_emp[k] = 1'b1;
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit wa, ra;
            wa = wr_en[k] && (mq[k].size() < dep[k]);
            ra = rd_en[k] && !m_emp[k];
            if (wr_en[k] && mq[k].size() == dep[k]) m_ovf[k] = 1'b1;
            if (rd_en[k] && m_emp[k])               m_unf[k] = 1'b1;
            if (ra) void'(mq[k].pop_front());
            if (wa) mq[k].push_back('{d: din[k], t: edge_no});
            m_emp[k] = !(mq[k].size() > 0 && mq[k][0].t < edge_no);
        end
        edge_no++;
    endtask

    task automatic check_all(input int k);
        int n;
        string s;
        n = mq[k].size();
        s = (k == 0) ? "d0" : "d1";
        check({s, "_count"}, cnt_of(k), n);
        check({s, "_empty"}, int'(empty[k]), int'(m_emp[k]));
        check({s, "_full"},  int'(full[k]),  int'(n == dep[k]));
        check({s, "_afull"}, int'(afull[k]), int'(n >= afl[k]));
        check({s, "_aempty"}, int'(aempty[k]), int'(n <= ael[k]));
        if (!m_emp[k]) check({s, "_dout"}, int'(dout[k]), int'(mq[k][0].d));
`ifdef LONG_FIFO_ERR_FLAG_EN
        check({s, "_overflow"},  int'(ovf[k]), int'(m_ovf[k]));
        check({s, "_underflow"}, int'(unf[k]), int'(m_unf[k]));
`else
        check({s, "_overflow"},  int'(ovf[k]), 0);
        check({s, "_underflow"}, int'(unf[k]), 0);
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            wr_en[k] = 1'b0;
            rd_en[k] = 1'b0;
            din[k]   = '0;
        end
    endtask

    task automatic check_reset_vals(input int k);
        check("rst_dout",   int'(dout[k]),   0);
        check("rst_empty",  int'(empty[k]),  1);
        check("rst_full",   int'(full[k]),   0);
        check("rst_aempty", int'(aempty[k]), 1);
        check("rst_afull",  int'(afull[k]),  0);
        check("rst_count",  cnt_of(k),       0);
        check("rst_ovf",    int'(ovf[k]),    0);
        check("rst_unf",    int'(unf[k]),    0);
    endtask

    typedef struct {
        int w, r, d, c, emp, fu, ae, af, dv;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{1, 0, 0,       1, 1, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 1,       2, 0, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 2,       3, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 3,       4, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 4,       5, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 5,       6, 0, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 6,       7, 0, 0, 0, 1, 0};
        tbl[7]  = '{1, 0, 7,       8, 0, 1, 0, 1, 0};
        tbl[8]  = '{1, 0, 'h3FFFF, 8, 0, 1, 0, 1, 0};
        tbl[9]  = '{0, 1, 0,       7, 0, 0, 0, 1, 1};
        tbl[10] = '{0, 1, 0,       6, 0, 0, 0, 1, 2};
        tbl[11] = '{0, 1, 0,       5, 0, 0, 0, 0, 3};
        tbl[12] = '{0, 1, 0,       4, 0, 0, 0, 0, 4};
        tbl[13] = '{0, 1, 0,       3, 0, 0, 0, 0, 5};
        tbl[14] = '{0, 1, 0,       2, 0, 0, 1, 0, 6};
        tbl[15] = '{0, 1, 0,       1, 0, 0, 1, 0, 7};
        tbl[16] = '{0, 1, 0,       0, 1, 0, 1, 0, 0};

        idle();
        model_reset();
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;

        // First write: visible one edge after it is accepted.
        wr_en[0] = 1'b1; din[0] = 18'h00001;
        tick();
        check("first_empty_still", int'(empty[0]), 1);
        check("first_count", cnt_of(0), 1);
        idle();
        tick();
        check("first_visible", int'(empty[0]), 0);
        check("first_dout", int'(dout[0]), 'h1);
        rd_en[0] = 1'b1;
        tick();
        idle();

        // Fill, overflow attempt, drain.
        for (int i = 0; i < 17; i++) begin
            wr_en[0] = tbl[i].w[0];
            rd_en[0] = tbl[i].r[0];
            din[0]   = 18'(tbl[i].d);
            tick();
            check($sformatf("tbl%0d_count", i), cnt_of(0), tbl[i].c);
            check($sformatf("tbl%0d_empty", i), int'(empty[0]), tbl[i].emp);
            check($sformatf("tbl%0d_full", i),  int'(full[0]),  tbl[i].fu);
            check($sformatf("tbl%0d_aempty", i), int'(aempty[0]), tbl[i].ae);
            check($sformatf("tbl%0d_afull", i), int'(afull[0]), tbl[i].af);
            if (tbl[i].emp == 0)
                check($sformatf("tbl%0d_dout", i), int'(dout[0]), tbl[i].dv);
`ifdef LONG_FIFO_ERR_FLAG_EN
            if (i == 8) check("overflow_set", int'(ovf[0]), 1);
`endif
        end
        idle();

        // Read while empty.
        rd_en[0] = 1'b1;
        tick();
        idle();
        check("unf_count", cnt_of(0), 0);
`ifdef LONG_FIFO_ERR_FLAG_EN
        check("underflow_set", int'(unf[0]), 1);
`else
        check("underflow_tied", int'(unf[0]), 0);
`endif

        // Sustained simultaneous traffic at count=4.
        for (int i = 0; i < 4; i++) begin
            wr_en[0] = 1'b1; din[0] = 18'(16'h100 + i);
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < 100; i++) begin
            wr_en[0] = 1'b1; rd_en[0] = 1'b1; din[0] = 18'(16'h200 + i);
            tick();
            if (empty[0] || count0 != 4'd4) check("stream_no_bubble", int'(count0), 4);
        end
        idle();
        check("stream_count", cnt_of(0), 4);
        for (int i = 0; i < 20 && (mq[0].size() > 0); i++) begin
            rd_en[0] = !m_emp[0];
            tick();
        end
        idle();
        tick();

        // Pointer wrap on the non-power-of-two instance.
        for (int i = 0; i < 50; i++) begin
            wr_en[1] = 1'b1; din[1] = 18'($urandom);
            rd_en[1] = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        for (int i = 0; i < 40 && (mq[1].size() > 0 || !m_emp[1]); i++) begin
            rd_en[1] = 1'b1;
            tick();
        end
        idle();
        tick();
        check("wrap_count0", int'(count1), 0);
        check("wrap_empty", int'(empty[1]), 1);

        // Random traffic on both instances with varying bias.
        for (int blk = 0; blk < 6; blk++) begin
            int pw, pr;
            pw = 20 + 12 * blk;
            pr = 80 - 12 * blk;
            for (int i = 0; i < 250; i++) begin
                for (int k = 0; k < 2; k++) begin
                    wr_en[k] = ($urandom_range(0, 99) < pw);
                    rd_en[k] = ($urandom_range(0, 99) < pr);
                    din[k]   = 18'($urandom);
                end
                tick();
            end
        end
        idle();

        // Asynchronous reset mid-burst at count=5.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en[0] = 1'b1; din[0] = 18'(16'h300 + i);
            tick();
        end
        check("burst_count5", cnt_of(0), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(0);
        model_reset();
        idle();
        tick();
        tick();
        @(negedge clock);
        rst_n = 1'b1;
        wr_en[0] = 1'b1; din[0] = 18'h2A5A5;
        tick();
        check("post_rst_empty", int'(empty[0]), 1);
        idle();
        tick();
        check("post_rst_visible", int'(empty[0]), 0);
        check("post_rst_dout", int'(dout[0]), 'h2A5A5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
